hybrid_startup_sequencer: RTL
=============================

// Module: hybrid_startup_sequencer
// PURPOSE
//  Supervises the hybrid resonant controller: releases its reset and slews the phi/ZVS angles from
//  safe start values to the requested references (soft-start), then tracks reference changes.
//  Masks the gate drive and trips to a latched FAULT on over-current or on a stalled switching
//  automaton. Sits between the user/config registers and the hybrid control block.
// PARAMETERS
//  PHI_START   32'sd0    phi applied at start of RAMP [deg, signed]
//  ZVS_START   32'sd90   ZVS angle applied at start of RAMP [deg, signed]
//  STEP        32'd1     angle increment per ramp tick [deg, >0]
//  RAMP_DIV    16'd5000  clock cycles per ramp tick (>=1)
//  ARM_CYCLES  16'd500   cycles controller reset is held released before gates enable
//  IC_LIMIT    14'd6000  over-current threshold on |iC| (unsigned, <=8191)
//  OC_FILT     8'd4      consecutive over-limit samples needed to trip (>=1)
//  WD_CYCLES   24'd250000 max cycles without an o_sigma change (watchdog build only)
// PORTS
//  i_clock        in   1   system clock
//  i_RESET        in   1   synchronous, active-high reset
//  i_enable       in   1   level: 1 = run converter, 0 = controlled stop
//  i_fault_clr    in   1   single-cycle pulse, clears latched fault
//  i_phi_ref      in   32s requested phi angle [deg]
//  i_ZVS_ref      in   32s requested ZVS angle [deg]
//  i_iC           in   14s tank current sample (same format as controller input)
//  i_sigma        in   2   controller sigma output (2-bit encoding)
//  o_phi          out  32s angle to controller i_phi
//  o_ZVS          out  32s angle to controller i_ZVS
//  o_ctrl_RESET   out  1   controller reset, ACTIVE-LOW (0 = hold controller in reset)
//  o_gate_en      out  1   AND-mask for all four MOSFET commands
//  o_fault        out  1   latched fault flag
//  o_fault_code   out  2   00 none, 01 over-current, 10 watchdog, 11 reserved
//  o_state        out  3   current FSM state encoding
// BEHAVIOUR
//  All outputs registered. Reset (i_RESET=1 at a rising edge): state IDLE, o_phi=PHI_START,
//   o_ZVS=ZVS_START, o_ctrl_RESET=0, o_gate_en=0, o_fault=0, o_fault_code=00, all counters 0.
//  States: IDLE=0 ARM=1 RAMP=2 RUN=3 STOP=4 FAULT=5.
//  IDLE : angles held at START values, ctrl reset asserted, gates off. i_enable=1 -> ARM.
//  ARM  : o_ctrl_RESET=1 from the first ARM cycle, gates off; after ARM_CYCLES cycles -> RAMP.
//         i_enable=0 during ARM -> IDLE.
//  RAMP : o_gate_en=1. Every RAMP_DIV cycles each angle moves one STEP toward its ref;
//         if |ref-angle| <= STEP the angle is loaded with ref exactly (no overshoot).
//         Both angles equal refs -> RUN on the next cycle. i_enable=0 -> STOP.
//  RUN  : same slew rule applied continuously (ref changes are slewed, never stepped).
//         i_enable=0 -> STOP.
//  STOP : gates stay on; angles slew back to START values at the ramp rate; when both equal
//         START -> IDLE (gates off, ctrl reset asserted same cycle). i_enable=1 in STOP -> RAMP
//         from current angle values (no re-arm).
//  FAULT: entered from ARM/RAMP/RUN/STOP. Same cycle as the entry edge: o_gate_en=0,
//         o_ctrl_RESET=0, o_fault=1, code latched; angles reset to START. Leaves to IDLE only on
//         i_fault_clr=1 with i_enable=0; i_fault_clr with i_enable=1 is ignored.
//  Over-current: |i_iC| computed in 14 bits, -8192 saturates to 8191. Counter increments each
//   cycle |iC|>IC_LIMIT, clears on any sample <=IC_LIMIT; reaching OC_FILT -> FAULT code 01.
//   Monitored in all states except IDLE and FAULT.
//  Priority at same edge: i_RESET > fault trip > i_enable change > ramp tick.
//  Angle arithmetic in 33-bit signed, results always within [min(start,ref),max(start,ref)].
//  Ramp tick divider restarts at 0 on every entry to RAMP, RUN or STOP.
// CONFIGURATION
//  SIGMA_WATCHDOG_EN defined: counter cleared on any change of i_sigma, incremented otherwise,
//   active only in RAMP/RUN/STOP; reaching WD_CYCLES -> FAULT code 10.
//  SIGMA_WATCHDOG_EN undefined: no watchdog logic; code 10 never produced.
// TESTING
//  1 Reset, enable=1, refs phi=30 ZVS=60, STEP=1 -> ARM for 500 cyc, RAMP, phi 0->30 and ZVS 90->60
//    in 30 ticks (30*RAMP_DIV cyc), then RUN; gate_en rises exactly at ARM->RAMP.
//  2 RUN, ref phi 30->33 with STEP=2 -> phi 32 then 33 on successive ticks, state stays RUN.
//  3 iC=+6001 for 3 cycles then 0, later -8192 for 4 cycles -> no trip first; FAULT code 01,
//    gate_en=0 and ctrl_RESET=0 on 4th cycle; fault_clr with enable=1 ignored, enable=0 -> IDLE.
//  4 RUN, enable=0 -> STOP, angles slew to 0/90, IDLE; enable=1 mid-STOP -> RAMP, no ARM.
//  5 (SIGMA_WATCHDOG_EN) sigma frozen in RUN -> FAULT code 10 after WD_CYCLES; without macro: no trip.
//  6 i_RESET=1 mid-RAMP -> next edge all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/hybrid_startup_sequencer.sv
// ---------------------------------------------------------------------------
// hybrid_startup_sequencer
//
// Supervisor for the hybrid resonant controller. Releases the controller
// reset, soft-starts the phi / ZVS angles from their safe start values to the
// requested references, then tracks reference changes at the same slew rate.
// Masks the gate drive and latches a fault on sustained over-current or, in
// the watchdog build, on a stalled sigma output.
//
// Build option:
//   SIGMA_WATCHDOG_EN  defined   -> sigma watchdog present (fault code 10)
//                      undefined -> no watchdog logic, code 10 never produced
//
// Ports:
//   i_clock       system clock
//   i_RESET       synchronous, active-high reset
//   i_enable      level: 1 = run converter, 0 = controlled stop
//   i_fault_clr   single-cycle pulse, clears latched fault (only with i_enable=0)
//   i_phi_ref     requested phi angle [deg, signed]
//   i_ZVS_ref     requested ZVS angle [deg, signed]
//   i_iC          tank current sample, 14-bit signed
//   i_sigma       controller sigma output
//   o_phi         angle to controller i_phi
//   o_ZVS         angle to controller i_ZVS
//   o_ctrl_RESET  controller reset, active-low (0 = hold in reset)
//   o_gate_en     AND-mask for the MOSFET commands
//   o_fault       latched fault flag
//   o_fault_code  00 none, 01 over-current, 10 watchdog
//   o_state       FSM state: IDLE=0 ARM=1 RAMP=2 RUN=3 STOP=4 FAULT=5
// ---------------------------------------------------------------------------
module hybrid_startup_sequencer #(
    parameter logic signed [31:0] PHI_START  = 32'sd0,
    parameter logic signed [31:0] ZVS_START  = 32'sd90,
    parameter logic        [31:0] STEP       = 32'd1,
    parameter logic        [15:0] RAMP_DIV   = 16'd5000,
    parameter logic        [15:0] ARM_CYCLES = 16'd500,
    parameter logic        [13:0] IC_LIMIT   = 14'd6000,
    parameter logic        [7:0]  OC_FILT    = 8'd4,
    parameter logic        [23:0] WD_CYCLES  = 24'd250000
) (
    input  logic               i_clock,
    input  logic               i_RESET,
    input  logic               i_enable,
    input  logic               i_fault_clr,
    input  logic signed [31:0] i_phi_ref,
    input  logic signed [31:0] i_ZVS_ref,
    input  logic signed [13:0] i_iC,
    input  logic        [1:0]  i_sigma,
    output logic signed [31:0] o_phi,
    output logic signed [31:0] o_ZVS,
    output logic               o_ctrl_RESET,
    output logic               o_gate_en,
    output logic               o_fault,
    output logic        [1:0]  o_fault_code,
    output logic        [2:0]  o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_RAMP  = 3'd2,
        S_RUN   = 3'd3,
        S_STOP  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t             state, state_n;
    logic        [15:0] arm_cnt, arm_cnt_n;
    logic        [15:0] div_cnt, div_cnt_n;
    logic        [7:0]  oc_cnt, oc_cnt_n;
    logic signed [31:0] phi_n, zvs_n;
    logic               gate_n, ctrl_n, fault_n;
    logic        [1:0]  code_n;
    logic        [13:0] ic_mag;
    logic               oc_over, oc_trip, wd_trip, monitored, tick_due;

    // One slew step toward tgt in 33-bit arithmetic so that the difference
    // between any two 32-bit angles cannot overflow; lands exactly on tgt
    // when it is within one STEP.
    function automatic logic signed [31:0] slew(input logic signed [31:0] cur,
                                                input logic signed [31:0] tgt);
        logic [32:0] cur_x, diff, mag, stp, nxt;
        cur_x = {cur[31], cur};
        diff  = {tgt[31], tgt} - cur_x;
        mag   = diff[32] ? (33'd0 - diff) : diff;
        stp   = {1'b0, STEP};
        if (mag <= stp) begin
            nxt = {tgt[31], tgt};
        end else if (diff[32]) begin
            nxt = cur_x - stp;
        end else begin
            nxt = cur_x + stp;
        end
        return 32'(nxt);
    endfunction

    // |iC| in 14 bits; -8192 has no positive counterpart and saturates.
    always_comb begin
        if (i_iC == 14'sh2000) begin
            ic_mag = 14'h1FFF;
        end else if (i_iC[13]) begin
            ic_mag = $unsigned(-i_iC);
        end else begin
            ic_mag = $unsigned(i_iC);
        end
    end

    assign oc_over   = ic_mag > IC_LIMIT;
    assign monitored = state inside {S_ARM, S_RAMP, S_RUN, S_STOP};
    assign oc_cnt_n  = (monitored && oc_over) ? oc_cnt + 8'd1 : '0;
    assign oc_trip   = monitored && oc_over && (({1'b0, oc_cnt} + 9'd1) >= {1'b0, OC_FILT});
    assign tick_due  = ({1'b0, div_cnt} + 17'd1) >= {1'b0, RAMP_DIV};

`ifdef SIGMA_WATCHDOG_EN
    logic [1:0]  sigma_prev;
    logic [23:0] wd_cnt, wd_cnt_n;
    logic        wd_stalled;

    assign wd_stalled = (state inside {S_RAMP, S_RUN, S_STOP}) && (i_sigma == sigma_prev);
    assign wd_cnt_n   = wd_stalled ? wd_cnt + 24'd1 : '0;
    assign wd_trip    = wd_stalled && (({1'b0, wd_cnt} + 25'd1) >= {1'b0, WD_CYCLES});

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            sigma_prev <= '0;
            wd_cnt     <= '0;
        end else begin
            sigma_prev <= i_sigma;
            wd_cnt     <= wd_cnt_n;
        end
    end
`else
    logic wd_unused;
    assign wd_unused = ^{i_sigma, WD_CYCLES};
    assign wd_trip   = 1'b0;
`endif

    // Next-state and next-output logic. The divider defaults to 0, so any
    // state change restarts the ramp tick; a tick is only applied when the
    // state is held, which gives trips and enable changes precedence.
    always_comb begin
        state_n   = state;
        arm_cnt_n = '0;
        div_cnt_n = '0;
        phi_n     = o_phi;
        zvs_n     = o_ZVS;
        fault_n   = o_fault;
        code_n    = o_fault_code;

        if (oc_trip || wd_trip) begin
            state_n = S_FAULT;
            fault_n = 1'b1;
            code_n  = oc_trip ? 2'b01 : 2'b10;
            phi_n   = PHI_START;
            zvs_n   = ZVS_START;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_enable) state_n = S_ARM;
                end
                S_ARM: begin
                    if (!i_enable) begin
                        state_n = S_IDLE;
                    end else if (({1'b0, arm_cnt} + 17'd1) >= {1'b0, ARM_CYCLES}) begin
                        state_n = S_RAMP;
                    end else begin
                        arm_cnt_n = arm_cnt + 16'd1;
                    end
                end
                S_RAMP, S_RUN: begin
                    if (!i_enable) begin
                        state_n = S_STOP;
                    end else if (state == S_RAMP && o_phi == i_phi_ref && o_ZVS == i_ZVS_ref) begin
                        state_n = S_RUN;
                    end else if (tick_due) begin
                        phi_n = slew(o_phi, i_phi_ref);
                        zvs_n = slew(o_ZVS, i_ZVS_ref);
                    end else begin
                        div_cnt_n = div_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (i_enable) begin
                        state_n = S_RAMP;
                    end else if (o_phi == PHI_START && o_ZVS == ZVS_START) begin
                        state_n = S_IDLE;
                    end else if (tick_due) begin
                        phi_n = slew(o_phi, PHI_START);
                        zvs_n = slew(o_ZVS, ZVS_START);
                    end else begin
                        div_cnt_n = div_cnt + 16'd1;
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr && !i_enable) begin
                        state_n = S_IDLE;
                        fault_n = 1'b0;
                        code_n  = 2'b00;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        gate_n = state_n inside {S_RAMP, S_RUN, S_STOP};
        ctrl_n = state_n inside {S_ARM, S_RAMP, S_RUN, S_STOP};
    end

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state        <= S_IDLE;
            arm_cnt      <= '0;
            div_cnt      <= '0;
            oc_cnt       <= '0;
            o_phi        <= PHI_START;
            o_ZVS        <= ZVS_START;
            o_ctrl_RESET <= 1'b0;
            o_gate_en    <= 1'b0;
            o_fault      <= 1'b0;
            o_fault_code <= 2'b00;
        end else begin
            state        <= state_n;
            arm_cnt      <= arm_cnt_n;
            div_cnt      <= div_cnt_n;
            oc_cnt       <= oc_cnt_n;
            o_phi        <= phi_n;
            o_ZVS        <= zvs_n;
            o_ctrl_RESET <= ctrl_n;
            o_gate_en    <= gate_n;
            o_fault      <= fault_n;
            o_fault_code <= code_n;
        end
    end

    assign o_state = state;

endmodule
